// File: rtl/axis_chk_pkg.sv
// Shared constants for the AXI4-Stream frame checker: FSM encodings, tuser
// marker positions, error bit positions, CRC-32 and LFSR parameters.
package axis_chk_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WAIT_SOL = 2'd1;
    localparam logic [1:0] ST_IN_LINE  = 2'd2;
    localparam logic [1:0] ST_DRAIN    = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE     = ST_IDLE,
        S_WAIT_SOL = ST_WAIT_SOL,
        S_IN_LINE  = ST_IN_LINE,
        S_DRAIN    = ST_DRAIN
    } fsm_state_e;

    localparam int unsigned TU_SOF = 0;
    localparam int unsigned TU_SOL = 1;
    localparam int unsigned TU_EOL = 2;
    localparam int unsigned TU_EOF = 3;

    localparam int unsigned ERR_MARKER = 0;
    localparam int unsigned ERR_LEN    = 1;
    localparam int unsigned ERR_COUNT  = 2;
    localparam int unsigned ERR_ABORT  = 3;

    localparam logic [31:0] CRC_POLY   = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_INIT   = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_XOROUT = 32'hFFFF_FFFF;

    localparam logic [15:0] LFSR_SEED  = 16'hACE1;

    function automatic logic [31:0] reflect32(input logic [31:0] v);
        logic [31:0] r;
        for (int unsigned i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/axis_frame_checker_crc.sv
// One-beat CRC-32 update (reflected form), bytes taken LSB first, each byte
// LSB first, so the result matches the usual Ethernet/zip CRC-32.
module crc32_beat
    import axis_chk_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic [31:0]           crc_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [31:0]           crc_o
);

    localparam logic [31:0] POLY_REFL = reflect32(CRC_POLY);

    always_comb begin
        logic [31:0] c;
        c = crc_i;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            if (c[0] ^ data_i[i]) begin
                c = (c >> 1) ^ POLY_REFL;
            end else begin
                c = c >> 1;
            end
        end
        crc_o = c;
    end

endmodule

// File: rtl/axis_frame_checker.sv
// AXI4-Stream video frame checker: validates SOF/SOL/EOL/EOF markers, line
// length and line count, accumulates a per-frame CRC-32, and can throttle tready.
module axis_frame_checker
    import axis_chk_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int MAX_DIM_W  = 13
) (
    input  logic                  axi_clk,
    input  logic                  axi_reset_n,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [3:0]            s_axis_tuser,
    input  logic                  cfg_enable,
    input  logic [MAX_DIM_W-1:0]  cfg_line_beats,
    input  logic [MAX_DIM_W-1:0]  cfg_line_count,
    input  logic                  cfg_bp_en,
    input  logic                  err_clr,
    output logic                  frame_done,
    output logic [31:0]           frame_cnt,
    output logic [3:0]            err_flags,
    output logic [31:0]           frame_crc
);

    fsm_state_e           state_q, state_d;
    logic [15:0]          lfsr_q, lfsr_d;
    logic [MAX_DIM_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [MAX_DIM_W-1:0] line_cnt_q, line_cnt_d;
    logic [31:0]          crc_q, crc_d;
    logic [3:0]           err_q, err_d;
    logic                 done_q, done_d;
    logic [31:0]          fcnt_q, fcnt_d;
    logic [31:0]          fcrc_q, fcrc_d;

    logic                 tu_sof, tu_sol, tu_eol, tu_eof;
    logic                 beat_acc, in_frame, frame_start, line_beat, line_end;
    logic [MAX_DIM_W-1:0] beats_base, beats_new, lines_base, lines_new;
    logic                 beat_sat, line_sat;
    logic [31:0]          crc_base, crc_beat;
    logic [3:0]           new_err;

    assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

    // tready is gated by reset so it reads low while reset is held
    assign s_axis_tready = axi_reset_n & cfg_enable & (~cfg_bp_en | lfsr_q[0]);
    assign beat_acc      = s_axis_tvalid & s_axis_tready;

    assign tu_sof   = s_axis_tuser[TU_SOF];
    assign tu_sol   = s_axis_tuser[TU_SOL];
    assign tu_eol   = s_axis_tuser[TU_EOL];
    assign tu_eof   = s_axis_tuser[TU_EOF];
    assign line_end = s_axis_tlast | tu_eol;

    assign in_frame    = (state_q == S_WAIT_SOL) || (state_q == S_IN_LINE);
    assign frame_start = beat_acc & tu_sof & (in_frame | ((state_q == S_IDLE) & tu_sol));
    assign line_beat   = beat_acc & (in_frame | frame_start);

    assign beats_base = frame_start ? '0 : beat_cnt_q;
    assign lines_base = frame_start ? '0 : line_cnt_q;
    assign beat_sat   = (beats_base == '1);
    assign line_sat   = (lines_base == '1);
    assign beats_new  = beat_sat ? beats_base : beats_base + MAX_DIM_W'(1);
    assign lines_new  = line_sat ? lines_base : lines_base + MAX_DIM_W'(1);
    assign crc_base   = frame_start ? CRC_INIT : crc_q;

    crc32_beat #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_crc (
        .crc_i  (crc_base),
        .data_i (s_axis_tdata),
        .crc_o  (crc_beat)
    );

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        line_cnt_d = line_cnt_q;
        crc_d      = crc_q;
        fcnt_d     = fcnt_q;
        fcrc_d     = fcrc_q;
        done_d     = 1'b0;
        new_err    = '0;

        if (in_frame && !cfg_enable) begin
            new_err[ERR_ABORT] = 1'b1;
            state_d            = S_DRAIN;
        end else if (state_q == S_DRAIN) begin
            if (cfg_enable) begin
                state_d = S_IDLE;
            end
        end else if (beat_acc && !line_beat) begin
            new_err[ERR_MARKER] = 1'b1;
        end else if (line_beat) begin
            if (frame_start && in_frame) begin
                new_err[ERR_MARKER] = 1'b1;
                new_err[ERR_ABORT]  = 1'b1;
            end
            // a missing SOL still belongs to the line being built
            if ((state_q == S_WAIT_SOL) && !tu_sol && !tu_sof) begin
                new_err[ERR_MARKER] = 1'b1;
            end
            crc_d      = crc_beat;
            beat_cnt_d = beats_new;
            line_cnt_d = lines_base;
            state_d    = S_IN_LINE;
            if (line_end) begin
                if (s_axis_tlast != tu_eol) begin
                    new_err[ERR_MARKER] = 1'b1;
                end
                if (beat_sat || (beats_new != cfg_line_beats)) begin
                    new_err[ERR_LEN] = 1'b1;
                end
                beat_cnt_d = '0;
                if (tu_eof) begin
                    if (line_sat || (lines_new != cfg_line_count)) begin
                        new_err[ERR_COUNT] = 1'b1;
                    end
                    line_cnt_d = '0;
                    state_d    = S_IDLE;
                    done_d     = 1'b1;
                    fcnt_d     = fcnt_q + 32'd1;
                    fcrc_d     = crc_beat ^ CRC_XOROUT;
                end else begin
                    line_cnt_d = lines_new;
                    state_d    = S_WAIT_SOL;
                end
            end
        end

        err_d = (err_clr ? 4'b0000 : err_q) | new_err;
    end

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            state_q    <= S_IDLE;
            lfsr_q     <= LFSR_SEED;
            beat_cnt_q <= '0;
            line_cnt_q <= '0;
            crc_q      <= '0;
            err_q      <= '0;
            done_q     <= 1'b0;
            fcnt_q     <= '0;
            fcrc_q     <= '0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            beat_cnt_q <= beat_cnt_d;
            line_cnt_q <= line_cnt_d;
            crc_q      <= crc_d;
            err_q      <= err_d;
            done_q     <= done_d;
            fcnt_q     <= fcnt_d;
            fcrc_q     <= fcrc_d;
        end
    end

    assign frame_done = done_q;
    assign frame_cnt  = fcnt_q;
    assign err_flags  = err_q;
    assign frame_crc  = fcrc_q;

endmodule

// File: tb/tb_axis_frame_checker.sv
// Directed bench for axis_frame_checker: table of frame scenarios plus
// hand-written sequences for error clear, abort, backpressure and reset.
module tb_axis_frame_checker;

    logic        axi_clk = 1'b0;
    logic        axi_reset_n;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic [63:0] s_axis_tdata;
    logic [3:0]  s_axis_tuser;
    logic        cfg_enable;
    logic [12:0] cfg_line_beats;
    logic [12:0] cfg_line_count;
    logic        cfg_bp_en;
    logic        err_clr;
    logic        frame_done;
    logic [31:0] frame_cnt;
    logic [3:0]  err_flags;
    logic [31:0] frame_crc;

    axis_frame_checker #(
        .DATA_WIDTH(64),
        .MAX_DIM_W (13)
    ) dut (
        .axi_clk        (axi_clk),
        .axi_reset_n    (axi_reset_n),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .s_axis_tlast   (s_axis_tlast),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tuser   (s_axis_tuser),
        .cfg_enable     (cfg_enable),
        .cfg_line_beats (cfg_line_beats),
        .cfg_line_count (cfg_line_count),
        .cfg_bp_en      (cfg_bp_en),
        .err_clr        (err_clr),
        .frame_done     (frame_done),
        .frame_cnt      (frame_cnt),
        .err_flags      (err_flags),
        .frame_crc      (frame_crc)
    );

    always #5 axi_clk = ~axi_clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          done_cnt = 0;
    logic        chk_rdy  = 1'b0;
    logic [31:0] m_reg;
    logic [15:0] lfsr_m;

    // Reference LFSR, taps 16,14,13,11 in right-shift form (bits 0,2,3,5)
    always @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) lfsr_m <= 16'hACE1;
        else              lfsr_m <= {^(lfsr_m & 16'h002D), lfsr_m[15:1]};
    end

    always @(negedge axi_clk) begin
        if (frame_done === 1'b1) done_cnt++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    function automatic logic [31:0] rev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    // MSB-first CRC-32 register fed with bit-reversed bytes, LSB byte first
    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [63:0] d);
        logic [31:0] r;
        r = c;
        for (int k = 0; k < 8; k++) begin
            r = r ^ {rev8(d[8*k +: 8]), 24'h0};
            for (int j = 0; j < 8; j++) begin
                r = r[31] ? ((r << 1) ^ 32'h04C11DB7) : (r << 1);
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] crc_final(input logic [31:0] r);
        return rev32(r) ^ 32'hFFFF_FFFF;
    endfunction

    task automatic send_beat(input logic [63:0] d, input logic [3:0] u, input logic l);
        int   waitc;
        logic rdy;
        waitc         = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        do begin
            @(negedge axi_clk);
            rdy = s_axis_tready;
            if (chk_rdy) check("tready_lfsr", {31'b0, rdy}, {31'b0, cfg_enable & lfsr_m[0]});
            @(posedge axi_clk);
            waitc++;
        end while (!rdy && waitc < 200);
        if (!rdy) check("handshake_timeout", 32'd0, 32'd1);
        #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic send_line(input int nb, input bit sof, input bit eof, input bit drop_eol);
        logic [63:0] d;
        logic [3:0]  u;
        for (int i = 0; i < nb; i++) begin
            d = {$urandom, $urandom};
            u = 4'b0000;
            if (i == 0) begin
                u[1] = 1'b1;
                u[0] = sof;
                if (sof) m_reg = 32'hFFFF_FFFF;
            end
            if (i == nb - 1) begin
                u[2] = ~drop_eol;
                u[3] = eof;
            end
            m_reg = crc_upd(m_reg, d);
            send_beat(d, u, i == nb - 1);
        end
    endtask

    task automatic run_frame(input int nlines, input int beats, input int short_idx,
                             input int short_beats, input int drop_idx);
        for (int ln = 0; ln < nlines; ln++) begin
            send_line((ln == short_idx) ? short_beats : beats, ln == 0, ln == nlines - 1,
                      ln == drop_idx);
        end
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(posedge axi_clk);
        #1 err_clr = 1'b0;
    endtask

    task automatic check_frame(input logic [3:0] exp_err, input int c0, input int d0);
        repeat (2) @(posedge axi_clk);
        #1;
        check("err_flags", {28'b0, err_flags}, {28'b0, exp_err});
        check("frame_cnt_delta", frame_cnt - c0, 32'd1);
        check("frame_done_pulses", done_cnt - d0, 32'd1);
        check("frame_crc", frame_crc, crc_final(m_reg));
    endtask

    typedef struct {
        int         pre_lines;
        int         nlines;
        int         short_idx;
        int         short_beats;
        int         beats;
        int         lines;
        int         drop_idx;
        logic [3:0] exp_err;
    } vec_t;

    vec_t vecs[7];
    int   c0, d0;

    initial begin
        vecs = '{
            '{0, 4, -1, 0, 8, 4, -1, 4'h0},   // clean 4x8
            '{0, 4,  1, 7, 8, 4, -1, 4'h2},   // line 2 one beat short
            '{1, 4, -1, 0, 8, 4, -1, 4'h9},   // SOF at start of line 2 restarts
            '{0, 1, -1, 0, 1, 1, -1, 4'h0},   // single-beat single-line frame
            '{0, 4, -1, 0, 8, 4,  0, 4'h1},   // tlast without EOL
            '{0, 2, -1, 0, 3, 2, -1, 4'h0},   // small clean frame
            '{0, 3, -1, 0, 8, 4, -1, 4'h4}    // 3 lines against cfg 4
        };

        axi_reset_n    = 1'b0;
        s_axis_tvalid  = 1'b0;
        s_axis_tlast   = 1'b0;
        s_axis_tdata   = '0;
        s_axis_tuser   = '0;
        cfg_enable     = 1'b1;
        cfg_line_beats = 13'd8;
        cfg_line_count = 13'd4;
        cfg_bp_en      = 1'b0;
        err_clr        = 1'b0;
        m_reg          = 32'hFFFF_FFFF;

        #2;
        check("reset_tready", {31'b0, s_axis_tready}, 32'd0);
        check("reset_frame_done", {31'b0, frame_done}, 32'd0);
        check("reset_frame_cnt", frame_cnt, 32'd0);
        check("reset_err_flags", {28'b0, err_flags}, 32'd0);
        check("reset_frame_crc", frame_crc, 32'd0);
        repeat (3) @(posedge axi_clk);
        #1 axi_reset_n = 1'b1;
        #1 check("tready_after_reset", {31'b0, s_axis_tready}, 32'd1);

        for (int v = 0; v < 7; v++) begin
            cfg_line_beats = 13'(vecs[v].beats);
            cfg_line_count = 13'(vecs[v].lines);
            pulse_clr();
            c0 = frame_cnt;
            d0 = done_cnt;
            for (int p = 0; p < vecs[v].pre_lines; p++) send_line(vecs[v].beats, 1'b1, 1'b0, 1'b0);
            run_frame(vecs[v].nlines, vecs[v].beats, vecs[v].short_idx, vecs[v].short_beats,
                      vecs[v].drop_idx);
            check_frame(vecs[v].exp_err, c0, d0);
        end

        // err_flags is 0x4 here; a clear coinciding with a new marker error keeps only the new one
        err_clr = 1'b1;
        send_beat(64'h1234, 4'b0000, 1'b0);
        err_clr = 1'b0;
        check("clr_vs_new_err", {28'b0, err_flags}, 32'h1);
        pulse_clr();
        check("err_clr_only", {28'b0, err_flags}, 32'h0);

        // disable mid-frame, then re-enable and run a clean frame
        cfg_line_beats = 13'd8;
        cfg_line_count = 13'd4;
        send_line(8, 1'b1, 1'b0, 1'b0);
        cfg_enable = 1'b0;
        @(posedge axi_clk);
        #1;
        check("abort_err", {28'b0, err_flags}, 32'h8);
        check("abort_tready", {31'b0, s_axis_tready}, 32'd0);
        repeat (3) @(posedge axi_clk);
        #1 cfg_enable = 1'b1;
        repeat (2) @(posedge axi_clk);
        #1;
        pulse_clr();
        c0 = frame_cnt;
        d0 = done_cnt;
        run_frame(4, 8, -1, 0, -1);
        check_frame(4'h0, c0, d0);

        // 100 frames under LFSR backpressure
        cfg_bp_en = 1'b1;
        chk_rdy   = 1'b1;
        c0 = frame_cnt;
        d0 = done_cnt;
        for (int f = 0; f < 100; f++) begin
            run_frame(4, 8, -1, 0, -1);
            @(posedge axi_clk);
            #1 check("bp_frame_crc", frame_crc, crc_final(m_reg));
        end
        repeat (2) @(posedge axi_clk);
        #1;
        chk_rdy = 1'b0;
        check("bp_err_flags", {28'b0, err_flags}, 32'h0);
        check("bp_frame_cnt_delta", frame_cnt - c0, 32'd100);
        check("bp_done_pulses", done_cnt - d0, 32'd100);
        cfg_bp_en = 1'b0;

        // reset in the middle of a line discards it silently
        send_beat(64'hAA, 4'b0011, 1'b0);
        send_beat(64'hBB, 4'b0000, 1'b0);
        send_beat(64'hCC, 4'b0000, 1'b0);
        #2 axi_reset_n = 1'b0;
        #1;
        check("midreset_err", {28'b0, err_flags}, 32'h0);
        check("midreset_cnt", frame_cnt, 32'd0);
        check("midreset_tready", {31'b0, s_axis_tready}, 32'd0);
        @(posedge axi_clk);
        #1 axi_reset_n = 1'b1;
        d0 = done_cnt;
        run_frame(4, 8, -1, 0, -1);
        check_frame(4'h0, 0, d0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
